mem_arbiter: RTL
================

# mem_arbiter

Arbiter and sequencer that shares one single-port unified memory between the pipelined core's instruction-fetch port and its data (MEM-stage) port. It latches the winning request, drives a req/gnt/rvalid handshake to the memory, and returns read data with a one-cycle valid pulse to the owner. It generates per-port stall signals for the hazard unit and supports killing a pending fetch on a branch or jump redirect.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; must be a multiple of 8
- STARVE, 3, maximum consecutive contested data grants before fetch is forced to win

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- i_req  in  1  fetch request; held until i_valid, or until i_kill
- i_addr  in  AW  fetch address
- i_kill  in  1  drop or discard the current fetch (redirect)
- i_valid  out  1  fetch complete; one-cycle pulse
- i_rdata  out  DW  fetched instruction; holds its value between pulses
- i_stall  out  1  i_req & ~i_valid
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_wstrb  in  DW/8  byte enables for stores
- d_valid  out  1  data access complete; one-cycle pulse, asserted for stores too
- d_rdata  out  DW  load data; holds its value between pulses
- d_stall  out  1  d_req & ~d_valid
- m_req  out  1  memory request
- m_we, m_addr, m_wdata, m_wstrb  out  1/AW/DW/DW/8  latched request fields; m_we = 0 and m_wstrb = 0 for fetches
- m_gnt  in  1  memory accepts request this cycle
- m_rvalid  in  1  access complete; m_rdata valid
- m_rdata  in  DW  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Choose a winner:
    - only d_req: data wins
    - only i_req (and not i_kill): fetch wins
    - both: data wins unless dcnt == STARVE, in which case fetch wins
  - Latch owner and request fields; go to ISSUE.
  - No request: stay in IDLE.
- **dcnt (starvation counter)**
  - Increments on a data grant while i_req is also high; saturates at STARVE.
  - Clears on any fetch grant.
- **ISSUE**
  - m_req = 1 with the latched fields; fields are stable until m_gnt.
  - m_gnt → WAIT.
  - Owner is fetch and i_kill = 1 before m_gnt → return to IDLE; no access is made and no valid is produced. Kill takes priority over m_gnt in the same cycle.
- **WAIT**
  - m_req = 0.
  - m_rvalid → capture m_rdata into the owner's rdata register (loads and fetches only); go to DONE.
  - i_kill while owner is fetch → set discard. At completion, a discarded fetch does not update i_rdata and does not pulse i_valid.
- **DONE**
  - The owner's valid is high for exactly this cycle (suppressed if discarded); then go to IDLE.
  - Requests are ignored in DONE. The requester deasserts or changes its request at the edge ending DONE.
- m_rvalid outside WAIT, and m_gnt outside ISSUE, are ignored.
- Memory contract: m_rvalid arrives no earlier than the cycle after m_gnt.
- Reset (rst_n = 0 at an edge)
  - state = IDLE, dcnt = 0, discard = 0, owner = data
  - i_valid = d_valid = 0, i_rdata = d_rdata = 0, m_req = 0, m_we = 0, m_addr = m_wdata = m_wstrb = 0
  - A reset mid-transaction abandons the access; the memory is reset by the same rst_n.

## Timing
- Request seen in IDLE at cycle 0 → m_req in cycle 1. With m_gnt in cycle 1 and m_rvalid in cycle 2, valid is asserted in cycle 3 and the FSM is back in IDLE in cycle 4.
- Minimum latency: 3 cycles. Maximum throughput: one access per 4 cycles. Each wait cycle on m_gnt or m_rvalid adds one cycle.
- i_valid, d_valid, the rdata outputs, and all m_* outputs are registered. The stall outputs and busy are combinational from registered state and the inputs.
- Stall is high from the request's first cycle through the cycle before valid; it is low during the DONE cycle.

## Test plan
- **Single load:** d_req = 1, d_we = 0, d_addr = 0x100; memory gives m_gnt in cycle 1 and m_rvalid with 0xDEADBEEF in cycle 2 → m_addr = 0x100 in cycle 1, d_valid and d_rdata = 0xDEADBEEF in cycle 3, d_stall high in cycles 0–2.
- **Store:** d_we = 1, d_wdata = 0x12345678, d_wstrb = 0x3 → m_we = 1, m_wstrb = 0x3 in ISSUE; d_valid pulses; d_rdata unchanged.
- **Contention and starvation** (STARVE = 3): i_req and d_req held continuously, with a fresh data request after each d_valid → grant order D, D, D, I, D, …; the fetch completes after the third data access.
- **Kill in ISSUE:** fetch in ISSUE with m_gnt held low, i_kill = 1 → next state IDLE, no m_gnt handshake completes, no i_valid.
- **Kill in WAIT:** i_kill pulsed in WAIT; memory returns 0xAAAA5555 → no i_valid; i_rdata keeps its prior value.
- **Reset mid-transaction:** rst_n = 0 during WAIT → next cycle state IDLE and all outputs 0; a late m_rvalid is ignored; the next request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports:
// picks a winner, runs the req/gnt/rvalid handshake and returns a valid pulse.
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int STARVE = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_kill,
  output logic            i_valid,
  output logic [DW-1:0]   i_rdata,
  output logic            i_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_stall,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [CW-1:0] STARVE_C = CW'(STARVE);

  logic [1:0]    r_state;
  logic          r_owner;   // 1 = fetch, 0 = data
  logic          r_discard;
  logic [CW-1:0] r_dcnt;

  logic w_i_ok;
  logic w_fetch_win;
  logic w_grant;
  logic w_drop_fetch;

  // Winner selection in IDLE; fetch is forced through once data has starved it.
  always_comb begin
    w_i_ok       = i_req & ~i_kill;
    w_fetch_win  = w_i_ok & (~d_req | (r_dcnt == STARVE_C));
    w_grant      = d_req | w_i_ok;
    w_drop_fetch = r_discard | i_kill;
  end

  assign i_stall = i_req & ~i_valid;
  assign d_stall = d_req & ~d_valid;
  assign busy    = (r_state != S_IDLE);

  // Sequencer state, latched request fields and returned data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_discard <= 1'b0;
      r_dcnt    <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state   <= S_ISSUE;
            m_req     <= 1'b1;
            r_discard <= 1'b0;
            if (w_fetch_win) begin
              r_owner <= 1'b1;
              m_we    <= 1'b0;
              m_addr  <= i_addr;
              m_wdata <= '0;
              m_wstrb <= '0;
              r_dcnt  <= '0;
            end else begin
              r_owner <= 1'b0;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_wstrb <= d_wstrb;
              if (i_req && (r_dcnt != STARVE_C)) begin
                r_dcnt <= r_dcnt + CW'(1);
              end else begin
                r_dcnt <= r_dcnt;
              end
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        // A redirect beats a same-cycle grant so the memory never sees the fetch.
        S_ISSUE: begin
          if (r_owner && i_kill) begin
            r_state <= S_IDLE;
            m_req   <= 1'b0;
          end else if (m_gnt) begin
            r_state <= S_WAIT;
            m_req   <= 1'b0;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_WAIT: begin
          if (m_rvalid) begin
            r_state <= S_DONE;
            if (r_owner) begin
              if (!w_drop_fetch) begin
                i_rdata <= m_rdata;
                i_valid <= 1'b1;
              end else begin
                i_valid <= 1'b0;
              end
            end else begin
              d_valid <= 1'b1;
              if (!m_we) begin
                d_rdata <= m_rdata;
              end else begin
                d_rdata <= d_rdata;
              end
            end
          end else begin
            r_state <= S_WAIT;
            if (r_owner && i_kill) begin
              r_discard <= 1'b1;
            end else begin
              r_discard <= r_discard;
            end
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_discard <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
